// File: rtl/adder_pipe.sv
// Pipelined add/sub with N/Z/C/V flags, carry split into SEGS registered segments of SW bits.
// Latency: an op accepted at edge t is presented on the outputs after edge t+SEGS-1.
// Backpressure: one global enable; the whole pipe, bubbles included, freezes while out_valid && !out_ready.
module adder_pipe #(
  parameter int WIDTH = 32,
  parameter int SEGS  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V
);

  localparam int SW   = WIDTH / SEGS;
  localparam int LAST = SEGS - 1;

  // Per-stage registers. Operand copies walk forward so that stage k
  // still has the untouched upper bits; sum copies carry the finished
  // lower segments forward to the output.
  logic             r_vld [SEGS];
  logic [WIDTH-1:0] r_a   [SEGS];
  logic [WIDTH-1:0] r_b   [SEGS];
  logic [WIDTH-1:0] r_sum [SEGS];
  logic             r_c   [SEGS];
  logic             r_z   [SEGS];
  logic             r_v;

  // Stage inputs (stage 0 from the ports, stage k from stage k-1).
  logic             w_v_in [SEGS];
  logic [WIDTH-1:0] w_a_in [SEGS];
  logic [WIDTH-1:0] w_b_in [SEGS];
  logic [WIDTH-1:0] w_s_in [SEGS];
  logic             w_c_in [SEGS];
  logic             w_z_in [SEGS];

  // Stage results to be registered.
  logic [SW:0]      w_seg    [SEGS];
  logic [WIDTH-1:0] w_sum_nx [SEGS];
  logic             w_co     [SEGS];
  logic             w_z_nx   [SEGS];

  logic             w_en;
  logic             w_inv_b;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c_eff;
  logic             w_cmsb;
  logic             w_v_nx;

  // Global enable: the pipe may move unless a finished result is being held.
  assign w_en     = !r_vld[LAST] || out_ready;
  assign in_ready = w_en;

  // B is inverted for both subtract modes (01, 10). Carry in: 00 and 10
  // take cin, 01 forces 1 (two's complement subtract), 11 forces 0.
  assign w_inv_b = op[0] ^ op[1];
  assign w_b_eff = w_inv_b ? ~b : b;
  assign w_c_eff = op[0] ? ~op[1] : cin;

  // Route each stage's inputs: ports into stage 0, previous registers onward.
  always_comb begin
    w_v_in[0] = in_valid && w_en;
    w_a_in[0] = a;
    w_b_in[0] = w_b_eff;
    w_s_in[0] = '0;
    w_c_in[0] = w_c_eff;
    w_z_in[0] = 1'b1;
    for (int k = 1; k < SEGS; k++) begin
      w_v_in[k] = r_vld[k-1];
      w_a_in[k] = r_a[k-1];
      w_b_in[k] = r_b[k-1];
      w_s_in[k] = r_sum[k-1];
      w_c_in[k] = r_c[k-1];
      w_z_in[k] = r_z[k-1];
    end
  end

  // Each stage ripples its own SW-bit segment and extends the running zero flag.
  always_comb begin
    for (int k = 0; k < SEGS; k++) begin
      w_seg[k]    = {1'b0, w_a_in[k][k*SW +: SW]}
                  + {1'b0, w_b_in[k][k*SW +: SW]}
                  + {{SW{1'b0}}, w_c_in[k]};
      w_sum_nx[k] = w_s_in[k];
      w_sum_nx[k][k*SW +: SW] = w_seg[k][SW-1:0];
      w_co[k]     = w_seg[k][SW];
      w_z_nx[k]   = w_z_in[k] && (w_seg[k][SW-1:0] == '0);
    end
  end

  // Carry into the MSB recovered from the MSB's own sum bit: s = a ^ b ^ c_in.
  // This also covers SW == 1, where it equals the incoming segment carry.
  assign w_cmsb = w_a_in[LAST][WIDTH-1] ^ w_b_in[LAST][WIDTH-1] ^ w_sum_nx[LAST][WIDTH-1];
  assign w_v_nx = w_cmsb ^ w_co[LAST];

  // Pipeline registers: clear asynchronously, shift together when enabled, else hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SEGS; k++) begin
        r_vld[k] <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
        r_c[k]   <= 1'b0;
        r_z[k]   <= 1'b0;
      end
      r_v <= 1'b0;
    end else if (w_en) begin
      for (int k = 0; k < SEGS; k++) begin
        r_vld[k] <= w_v_in[k];
        r_a[k]   <= w_a_in[k];
        r_b[k]   <= w_b_in[k];
        r_sum[k] <= w_sum_nx[k];
        r_c[k]   <= w_co[k];
        r_z[k]   <= w_z_nx[k];
      end
      r_v <= w_v_nx;
    end
  end

  assign out_valid = r_vld[LAST];
  assign sum       = r_sum[LAST];
  assign N         = r_sum[LAST][WIDTH-1];
  assign Z         = r_z[LAST];
  assign C         = r_c[LAST];
  assign V         = r_v;

endmodule

// File: tb/tb_adder_pipe.sv
// Directed bench for adder_pipe in three shapes: 32b/4 segments, 8b/1 segment, 8b/8 segments.
// Expected sums and flags are hand-computed constants; the stream phase checks order and stall behaviour.
// All stimulus runs as one linear sequence; outputs are sampled 1-2 time units after the rising edge.
module tb_adder_pipe;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // 32-bit, 4-segment instance
  logic        d0_in_valid, d0_in_ready, d0_cin, d0_out_valid, d0_out_ready;
  logic        d0_n, d0_z, d0_c, d0_v;
  logic [1:0]  d0_op;
  logic [31:0] d0_a, d0_b, d0_sum;

  // 8-bit, 1-segment instance
  logic        d1_in_valid, d1_in_ready, d1_cin, d1_out_valid, d1_out_ready;
  logic        d1_n, d1_z, d1_c, d1_v;
  logic [1:0]  d1_op;
  logic [7:0]  d1_a, d1_b, d1_sum;

  // 8-bit, 8-segment instance
  logic        d2_in_valid, d2_in_ready, d2_cin, d2_out_valid, d2_out_ready;
  logic        d2_n, d2_z, d2_c, d2_v;
  logic [1:0]  d2_op;
  logic [7:0]  d2_a, d2_b, d2_sum;

  adder_pipe #(.WIDTH(32), .SEGS(4)) u_d0 (
    .clk(clk), .reset(reset), .in_valid(d0_in_valid), .in_ready(d0_in_ready),
    .a(d0_a), .b(d0_b), .cin(d0_cin), .op(d0_op),
    .out_valid(d0_out_valid), .out_ready(d0_out_ready), .sum(d0_sum),
    .N(d0_n), .Z(d0_z), .C(d0_c), .V(d0_v)
  );

  adder_pipe #(.WIDTH(8), .SEGS(1)) u_d1 (
    .clk(clk), .reset(reset), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
    .a(d1_a), .b(d1_b), .cin(d1_cin), .op(d1_op),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready), .sum(d1_sum),
    .N(d1_n), .Z(d1_z), .C(d1_c), .V(d1_v)
  );

  adder_pipe #(.WIDTH(8), .SEGS(8)) u_d2 (
    .clk(clk), .reset(reset), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
    .a(d2_a), .b(d2_b), .cin(d2_cin), .op(d2_op),
    .out_valid(d2_out_valid), .out_ready(d2_out_ready), .sum(d2_sum),
    .N(d2_n), .Z(d2_z), .C(d2_c), .V(d2_v)
  );

  // Stream table: op, a, b, cin and the hand-computed sum and {N,Z,C,V}.
  logic [1:0]  t_op [8];
  logic [31:0] t_a  [8];
  logic [31:0] t_b  [8];
  logic        t_cin[8];
  logic [31:0] t_s  [8];
  logic [3:0]  t_f  [8];
  logic [31:0] rdy_pat;
  int          sent;
  int          recv;
  logic        hold_vld;
  logic [31:0] hold_sum;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One op through the 32/4 instance with out_ready held high.
  task automatic op32(input string tag, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic cin,
                      input logic [31:0] es, input logic [3:0] ef);
    chk({tag, "_in_ready"}, {31'd0, d0_in_ready}, 32'd1);
    d0_op = op; d0_a = a; d0_b = b; d0_cin = cin; d0_in_valid = 1'b1;
    tick();
    d0_in_valid = 1'b0;
    d0_a = 32'hDEAD_BEEF; d0_b = 32'h0BAD_F00D; d0_cin = ~cin; d0_op = ~op;
    tick();
    tick();
    chk({tag, "_early_vld"}, {31'd0, d0_out_valid}, 32'd0);
    tick();
    chk({tag, "_vld"}, {31'd0, d0_out_valid}, 32'd1);
    chk({tag, "_sum"}, d0_sum, es);
    chk({tag, "_nzcv"}, {28'd0, d0_n, d0_z, d0_c, d0_v}, {28'd0, ef});
  endtask

  initial begin
    d0_in_valid = 0; d0_out_ready = 1; d0_cin = 0; d0_op = 0; d0_a = 0; d0_b = 0;
    d1_in_valid = 0; d1_out_ready = 1; d1_cin = 0; d1_op = 0; d1_a = 0; d1_b = 0;
    d2_in_valid = 0; d2_out_ready = 1; d2_cin = 0; d2_op = 0; d2_a = 0; d2_b = 0;

    t_op  = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b11};
    t_a   = '{32'h0000_0001, 32'h0000_0010, 32'hFFFF_0000, 32'h0000_0005,
              32'h8000_0000, 32'h8000_0000, 32'h1234_5678, 32'h0000_FFFF};
    t_b   = '{32'h0000_0002, 32'h0000_0003, 32'h0000_FFFF, 32'h0000_0002,
              32'h8000_0000, 32'h0000_0001, 32'h1111_1111, 32'h0000_0001};
    t_cin = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    t_s   = '{32'h0000_0003, 32'h0000_000D, 32'h0000_0000, 32'h0000_0002,
              32'h0000_0000, 32'h7FFF_FFFF, 32'h2345_6789, 32'h0001_0000};
    t_f   = '{4'b0000, 4'b0010, 4'b0110, 4'b0010, 4'b0111, 4'b0011, 4'b0000, 4'b0000};
    rdy_pat = 32'b1011_0010_1110_0111_0101_1001_1110_1011;

    // Reset state
    #3;
    chk("rst_vld0", {31'd0, d0_out_valid}, 32'd0);
    chk("rst_sum0", d0_sum, 32'd0);
    chk("rst_nzcv0", {28'd0, d0_n, d0_z, d0_c, d0_v}, 32'd0);
    chk("rst_vld1", {31'd0, d1_out_valid}, 32'd0);
    chk("rst_vld2", {31'd0, d2_out_valid}, 32'd0);
    #9 reset = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, d0_in_ready}, 32'd1);

    // Directed ops, 32/4
    op32("add_ovf",   2'b11, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b1001);
    op32("sub_zero",  2'b01, 32'h0000_0005, 32'h0000_0005, 1'b0, 32'h0000_0000, 4'b0110);
    op32("sub_borrow",2'b01, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 4'b1000);
    op32("adc_ripple",2'b00, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 4'b0110);
    op32("add_nocin", 2'b11, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 4'b1000);
    op32("sbc_cin1",  2'b10, 32'h0000_0010, 32'h0000_0001, 1'b1, 32'h0000_000F, 4'b0010);

    // Drain, then fill the pipe while the consumer stalls
    tick();
    chk("drain_vld", {31'd0, d0_out_valid}, 32'd0);
    d0_out_ready = 1'b0;
    d0_in_valid = 1'b1; d0_op = 2'b11; d0_b = 32'd1; d0_cin = 1'b0;
    d0_a = 32'd1; tick();
    d0_a = 32'd2; tick();
    d0_a = 32'd3; tick();
    d0_a = 32'd4; tick();
    d0_in_valid = 1'b0;
    chk("stall_vld", {31'd0, d0_out_valid}, 32'd1);
    chk("stall_sum", d0_sum, 32'd2);
    chk("stall_in_ready", {31'd0, d0_in_ready}, 32'd0);
    tick();
    chk("stall_hold_sum", d0_sum, 32'd2);
    chk("stall_hold_vld", {31'd0, d0_out_valid}, 32'd1);

    // Asynchronous reset with ops in flight
    #2 reset = 1'b1;
    #1;
    chk("arst_vld", {31'd0, d0_out_valid}, 32'd0);
    chk("arst_sum", d0_sum, 32'd0);
    chk("arst_nzcv", {28'd0, d0_n, d0_z, d0_c, d0_v}, 32'd0);
    #2 reset = 1'b0;
    d0_out_ready = 1'b1;
    op32("post_rst", 2'b11, 32'h0000_0100, 32'h0000_0023, 1'b0, 32'h0000_0123, 4'b0000);
    repeat (5) tick();
    chk("post_rst_empty", {31'd0, d0_out_valid}, 32'd0);

    // Stream of 8 ops against a fixed out_ready pattern
    sent = 0; recv = 0; hold_vld = 1'b0; hold_sum = '0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      d0_out_ready = rdy_pat[cyc % 32];
      if (sent < 8) begin
        d0_in_valid = 1'b1;
        d0_op = t_op[sent]; d0_a = t_a[sent]; d0_b = t_b[sent]; d0_cin = t_cin[sent];
      end else begin
        d0_in_valid = 1'b0;
      end
      #1;
      if (hold_vld) chk("stream_stall_sum", d0_sum, hold_sum);
      chk("stream_in_ready", {31'd0, d0_in_ready}, {31'd0, !(d0_out_valid && !d0_out_ready)});
      if (d0_out_valid && d0_out_ready) begin
        if (recv < 8) begin
          chk("stream_sum", d0_sum, t_s[recv]);
          chk("stream_nzcv", {28'd0, d0_n, d0_z, d0_c, d0_v}, {28'd0, t_f[recv]});
        end else begin
          chk("stream_extra_vld", {31'd0, d0_out_valid}, 32'd0);
        end
        recv++;
      end
      hold_vld = d0_out_valid && !d0_out_ready;
      hold_sum = d0_sum;
      if (d0_in_valid && d0_in_ready) sent++;
      tick();
      if (sent == 8 && recv == 8) break;
    end
    chk("stream_sent", sent, 32'd8);
    chk("stream_recv", recv, 32'd8);
    d0_in_valid = 1'b0;
    d0_out_ready = 1'b1;
    repeat (5) tick();
    chk("stream_empty", {31'd0, d0_out_valid}, 32'd0);

    // 8-bit, single segment: result one cycle after acceptance
    chk("s1_in_ready", {31'd0, d1_in_ready}, 32'd1);
    d1_op = 2'b01; d1_a = 8'h80; d1_b = 8'h01; d1_cin = 1'b0; d1_in_valid = 1'b1;
    chk("s1_pre_vld", {31'd0, d1_out_valid}, 32'd0);
    tick();
    d1_in_valid = 1'b0;
    chk("s1_vld", {31'd0, d1_out_valid}, 32'd1);
    chk("s1_sum", {24'd0, d1_sum}, 32'h7F);
    chk("s1_nzcv", {28'd0, d1_n, d1_z, d1_c, d1_v}, 32'b0011);

    // 8-bit, eight one-bit segments: subtract with carry
    d2_op = 2'b10; d2_a = 8'h10; d2_b = 8'h01; d2_cin = 1'b0; d2_in_valid = 1'b1;
    chk("s8_in_ready", {31'd0, d2_in_ready}, 32'd1);
    tick();
    d2_in_valid = 1'b0; d2_a = 8'hA5; d2_b = 8'h5A;
    repeat (6) tick();
    chk("s8_early_vld", {31'd0, d2_out_valid}, 32'd0);
    tick();
    chk("s8_vld", {31'd0, d2_out_valid}, 32'd1);
    chk("s8_sum", {24'd0, d2_sum}, 32'h0E);
    chk("s8_nzcv", {28'd0, d2_n, d2_z, d2_c, d2_v}, 32'b0010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
